// File: rtl/im_slave_pkg.sv
// Shared types and encodings for the instruction-SRAM AXI read slave.
// Holds the FSM state enum and the AXI response/burst codes.
package im_slave_pkg;

  typedef enum logic {
    IDLE,
    DATA
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;

endpackage : im_slave_pkg

// File: rtl/axi_burst_counter.sv
// Burst bookkeeping for the read slave: current word address, beat index,
// burst length and FIXED flag; produces the next address and the last-beat flag.
module axi_burst_counter #(
  parameter int LEN_W   = 4,
  parameter int SRAM_AW = 14
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               advance,
  input  logic [SRAM_AW-1:0] load_addr,
  input  logic [LEN_W-1:0]   load_len,
  input  logic               load_fixed,
  output logic [SRAM_AW-1:0] addr_q,
  output logic [SRAM_AW-1:0] next_addr,
  output logic               last
);

  logic [LEN_W-1:0] beat_q;
  logic [LEN_W-1:0] len_q;
  logic             fixed_q;

  // The SRAM word address wraps naturally at 2^SRAM_AW.
  assign next_addr = fixed_q ? addr_q : addr_q + SRAM_AW'(1);
  assign last      = (beat_q == len_q);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order within the block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      beat_q  <= '0;
      len_q   <= '0;
      fixed_q <= 1'b0;
    end else if (load) begin
      addr_q  <= load_addr;
      beat_q  <= '0;
      len_q   <= load_len;
      fixed_q <= load_fixed;
    end else if (advance) begin
      addr_q  <= next_addr;
      beat_q  <= beat_q + LEN_W'(1);
    end
  end

endmodule : axi_burst_counter

// File: rtl/im_axi_read_slave.sv
// AXI4 read-only slave in front of a 1-cycle-latency instruction SRAM.
// One AR burst at a time, one beat per cycle, RREADY backpressure honoured.
module im_axi_read_slave
  import im_slave_pkg::*;
#(
  parameter int ID_W    = 8,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int LEN_W   = 4,
  parameter int SRAM_AW = 14
) (
  input  logic               ACLK,
  input  logic               ARESETn,
  input  logic [ID_W-1:0]    ARID_S,
  input  logic [ADDR_W-1:0]  ARADDR_S,
  input  logic [LEN_W-1:0]   ARLEN_S,
  input  logic [2:0]         ARSIZE_S,
  input  logic [1:0]         ARBURST_S,
  input  logic               ARVALID_S,
  output logic               ARREADY_S,
  output logic [ID_W-1:0]    RID_S,
  output logic [DATA_W-1:0]  RDATA_S,
  output logic [1:0]         RRESP_S,
  output logic               RLAST_S,
  output logic               RVALID_S,
  input  logic               RREADY_S,
  output logic               sram_CEB,
  output logic [SRAM_AW-1:0] sram_A,
  input  logic [DATA_W-1:0]  sram_DO
);

  state_e             state_q, state_d;
  logic [ID_W-1:0]    rid_q;
  logic [SRAM_AW-1:0] addr_q, next_addr;
  logic [SRAM_AW-1:0] ar_word;
  logic               last;
  logic               ar_hs, advance;

  // Transfer size is fixed at 4 bytes; byte offset and high address bits are ignored.
  logic unused_ok;
  assign unused_ok = ^{ARSIZE_S, ARADDR_S[ADDR_W-1:SRAM_AW+2], ARADDR_S[1:0]};

  assign ar_word = ARADDR_S[SRAM_AW+1:2];
  assign ar_hs   = (state_q == IDLE) && ARVALID_S;
  assign advance = (state_q == DATA) && RREADY_S && !last;

  axi_burst_counter #(
    .LEN_W   (LEN_W),
    .SRAM_AW (SRAM_AW)
  ) u_burst_counter (
    .clk        (ACLK),
    .rst_n      (ARESETn),
    .load       (ar_hs),
    .advance    (advance),
    .load_addr  (ar_word),
    .load_len   (ARLEN_S),
    .load_fixed (ARBURST_S == BURST_FIXED),
    .addr_q     (addr_q),
    .next_addr  (next_addr),
    .last       (last)
  );

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q <= IDLE;
      rid_q   <= '0;
    end else begin
      state_q <= state_d;
      if (ar_hs) rid_q <= ARID_S;
    end
  end

  // NOTE: every output of this block is given a default first, so no path
  // through the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    ARREADY_S = 1'b0;
    RVALID_S  = 1'b0;
    RLAST_S   = 1'b0;
    sram_CEB  = 1'b1;
    sram_A    = addr_q;
    unique case (state_q)
      IDLE: begin
        ARREADY_S = 1'b1;
        sram_A    = ar_word;
        sram_CEB  = ~ARVALID_S;
        if (ARVALID_S) state_d = DATA;
      end
      DATA: begin
        RVALID_S = 1'b1;
        RLAST_S  = last;
        if (RREADY_S) begin
          if (last) begin
            state_d = IDLE;
          end else begin
            // Fetch the next beat now so it lands on RDATA the following cycle.
            sram_CEB = 1'b0;
            sram_A   = next_addr;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The SRAM holds its output while CEB is high, which keeps RDATA stable on a stall.
  assign RDATA_S = sram_DO;
  assign RID_S   = rid_q;
  assign RRESP_S = RESP_OKAY;

endmodule : im_axi_read_slave

// File: tb/tb_im_axi_read_slave.sv
// Self-checking bench for im_axi_read_slave: table of AR bursts, an SRAM model,
// and a scoreboard of expected R beats compared on the falling clock edge.
module tb_im_axi_read_slave;
  import im_slave_pkg::*;

  localparam int SRAM_AW = 14;

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b0;
  logic [7:0]  ARID_S = '0;
  logic [31:0] ARADDR_S = '0;
  logic [3:0]  ARLEN_S = '0;
  logic [2:0]  ARSIZE_S = 3'b010;
  logic [1:0]  ARBURST_S = BURST_INCR;
  logic        ARVALID_S = 1'b0;
  logic        ARREADY_S;
  logic [7:0]  RID_S;
  logic [31:0] RDATA_S;
  logic [1:0]  RRESP_S;
  logic        RLAST_S;
  logic        RVALID_S;
  logic        RREADY_S = 1'b1;
  logic        sram_CEB;
  logic [SRAM_AW-1:0] sram_A;
  logic [31:0] sram_DO = '0;

  im_axi_read_slave dut (
    .ACLK      (ACLK),
    .ARESETn   (ARESETn),
    .ARID_S    (ARID_S),
    .ARADDR_S  (ARADDR_S),
    .ARLEN_S   (ARLEN_S),
    .ARSIZE_S  (ARSIZE_S),
    .ARBURST_S (ARBURST_S),
    .ARVALID_S (ARVALID_S),
    .ARREADY_S (ARREADY_S),
    .RID_S     (RID_S),
    .RDATA_S   (RDATA_S),
    .RRESP_S   (RRESP_S),
    .RLAST_S   (RLAST_S),
    .RVALID_S  (RVALID_S),
    .RREADY_S  (RREADY_S),
    .sram_CEB  (sram_CEB),
    .sram_A    (sram_A),
    .sram_DO   (sram_DO)
  );

  always #5 ACLK = ~ACLK;

  // SRAM model: one-cycle read latency, output held while CEB is high.
  logic [31:0] mem [0:(1<<SRAM_AW)-1];
  always @(posedge ACLK) if (!sram_CEB) sram_DO <= mem[sram_A];

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic [7:0]  id;
  } beat_t;
  beat_t sb[$];

  typedef struct {
    logic [7:0]         id;
    logic [31:0]        addr;
    logic [3:0]         len;
    logic [1:0]         burst;
    int                 stall_beat;
    int                 stall_cycles;
    bit                 ar_hold;
    logic [SRAM_AW-1:0] exp_w0;
  } vec_t;
  vec_t vecs[7];

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  // Scoreboard consumer: each R handshake pops one expected beat; a stall must
  // keep the SRAM idle and the current beat's data stable.
  always @(negedge ACLK) begin
    if (ARESETn) begin
      if (RVALID_S && RREADY_S) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_beat: got rdata %h with no beat expected", RDATA_S);
        end else begin
          beat_t e;
          e = sb.pop_front();
          check("rdata", RDATA_S, e.data);
          check("rlast", 32'(RLAST_S), 32'(e.last));
          check("rid", 32'(RID_S), 32'(e.id));
          check("rresp", 32'(RRESP_S), 32'(RESP_OKAY));
        end
      end else if (RVALID_S) begin
        check("stall_ceb", 32'(sram_CEB), 32'd1);
        if (sb.size() != 0) check("stall_rdata", RDATA_S, sb[0].data);
      end
    end
  end

  task automatic run_burst(input vec_t v);
    logic [SRAM_AW-1:0] w;
    ARID_S    = v.id;
    ARADDR_S  = v.addr;
    ARLEN_S   = v.len;
    ARBURST_S = v.burst;
    ARVALID_S = 1'b1;
    #1;
    check("ar_ready", 32'(ARREADY_S), 32'd1);
    check("ar_ceb", 32'(sram_CEB), 32'd0);
    check("ar_sram_a", 32'(sram_A), 32'(v.exp_w0));
    for (int b = 0; b <= int'(v.len); b++) begin
      w = (v.burst == BURST_FIXED) ? v.exp_w0 : v.exp_w0 + SRAM_AW'(b);
      sb.push_back('{data: mem[w], last: (b == int'(v.len)), id: v.id});
    end
    step();
    if (!v.ar_hold) ARVALID_S = 1'b0;
    #1;
    check("rvalid_t1", 32'(RVALID_S), 32'd1);
    for (int b = 0; b <= int'(v.len); b++) begin
      if (b == int'(v.len)) ARVALID_S = 1'b0;
      if (v.ar_hold) check("arready_busy", 32'(ARREADY_S), 32'd0);
      if (b == v.stall_beat) begin
        RREADY_S = 1'b0;
        repeat (v.stall_cycles) step();
        RREADY_S = 1'b1;
      end
      step();
    end
    #1;
    check("arready_after", 32'(ARREADY_S), 32'd1);
    check("rvalid_after", 32'(RVALID_S), 32'd0);
    check("beats_left", sb.size(), 32'd0);
    sb.delete();
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < (1 << SRAM_AW); i++) mem[i] = (i * 32'h9E37_79B1) + 32'h1357_0001;
    mem[16] = 32'hDEAD_BEEF;

    //          id     addr          len   burst        stall  cyc hold exp_w0
    vecs[0] = '{8'h12, 32'h0000_0040, 4'd0,  BURST_INCR,  -1,    0,  0, 14'd16};
    vecs[1] = '{8'h34, 32'h0000_0100, 4'd3,  BURST_INCR,  -1,    0,  0, 14'd64};
    vecs[2] = '{8'h35, 32'h0000_0100, 4'd3,  BURST_INCR,   1,    3,  0, 14'd64};
    vecs[3] = '{8'h56, 32'h0000_0020, 4'd2,  BURST_FIXED, -1,    0,  0, 14'd8};
    vecs[4] = '{8'h78, 32'hABCD_FFFB, 4'd3,  BURST_INCR,   2,    1,  0, 14'h3FFE};
    vecs[5] = '{8'h9A, 32'h0000_0204, 4'd1,  2'b10,       -1,    0,  1, 14'd129};
    vecs[6] = '{8'hBC, 32'h0000_1000, 4'd15, BURST_INCR,  15,    2,  0, 14'd1024};

    // Reset state, with ARVALID low.
    repeat (3) step();
    check("rst_arready", 32'(ARREADY_S), 32'd1);
    check("rst_rvalid", 32'(RVALID_S), 32'd0);
    check("rst_rlast", 32'(RLAST_S), 32'd0);
    check("rst_rid", 32'(RID_S), 32'd0);
    check("rst_ceb", 32'(sram_CEB), 32'd1);
    ARESETn = 1'b1;
    step();

    for (int i = 0; i < 7; i++) run_burst(vecs[i]);

    // Reset in the middle of a 4-beat burst, after beats 0 and 1 are taken.
    ARID_S    = 8'h77;
    ARADDR_S  = 32'h0000_0100;
    ARLEN_S   = 4'd3;
    ARBURST_S = BURST_INCR;
    ARVALID_S = 1'b1;
    for (int b = 0; b < 4; b++) sb.push_back('{data: mem[64+b], last: (b == 3), id: 8'h77});
    step();
    ARVALID_S = 1'b0;
    step();
    step();
    check("mid_beats_taken", sb.size(), 32'd2);
    check("mid_rvalid", 32'(RVALID_S), 32'd1);
    ARESETn = 1'b0;
    #1;
    check("async_rvalid", 32'(RVALID_S), 32'd0);
    check("async_rlast", 32'(RLAST_S), 32'd0);
    sb.delete();
    step();
    check("inrst_arready", 32'(ARREADY_S), 32'd1);
    check("inrst_rid", 32'(RID_S), 32'd0);
    ARESETn = 1'b1;
    step();
    run_burst(vecs[1]);
    run_burst(vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_im_axi_read_slave
